// File: rtl/mem_port_arb_if.sv
// Bundle of the instruction-fetch port, the data port and the shared memory
// command port of the memory port arbiter.
// The master modport is the arbiter's view of the bundle.
// The slave modport is the view of the requesters and the memory.
interface mem_port_arb_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_stall;

    logic        d_req;
    logic        d_wr_en;
    logic [1:0]  d_size;
    logic        d_sz_ex;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;

    logic        m_req;
    logic        m_wr_en;
    logic [1:0]  m_size;
    logic        m_sz_ex;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_rdy;

    logic        err;

    modport master (
        input  i_req, i_addr, d_req, d_wr_en, d_size, d_sz_ex, d_addr, d_wdata,
               m_rdata, m_rdy,
        output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
               m_req, m_wr_en, m_size, m_sz_ex, m_addr, m_wdata, err
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr_en, d_size, d_sz_ex, d_addr, d_wdata,
               m_rdata, m_rdy,
        input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
               m_req, m_wr_en, m_size, m_sz_ex, m_addr, m_wdata, err
    );
endinterface

// File: rtl/mem_port_arb.sv
// Arbiter that shares one variable-latency memory port between an
// instruction-fetch requester and a data requester.
// Conflicts in IDLE go to the requester not granted last. Data wins the
// first conflict after reset.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT busy cycles without m_rdy. The abort returns zero data and pulses err.
module mem_port_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_arb_if.master bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t state;
    logic   last_d;
    logic   i_cand;
    logic   d_cand;
    logic   grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] busy_cnt;
    logic          timed_out;

    assign timed_out = (busy_cnt == CW'(TIMEOUT - 1));
`else
    // Without the watchdog err never fires. The expression still names
    // TIMEOUT so the parameter keeps a reader in this build.
    assign bus.err = (TIMEOUT < 0);
`endif

    // A requester whose ack is high this cycle is showing a stale request.
    // On a conflict, data wins unless data was the last one granted.
    assign i_cand  = bus.i_req & ~bus.i_ack;
    assign d_cand  = bus.d_req & ~bus.d_ack;
    assign grant_d = d_cand & (~i_cand | ~last_d);

    assign bus.i_stall = bus.i_req & ~bus.i_ack;
    assign bus.d_stall = bus.d_req & ~bus.d_ack;

    // Arbitration FSM with registered command, ack and read-data outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_d      <= 1'b0;
            bus.m_req   <= 1'b0;
            bus.m_wr_en <= 1'b0;
            bus.m_size  <= 2'b00;
            bus.m_sz_ex <= 1'b0;
            bus.m_addr  <= 32'h0;
            bus.m_wdata <= 32'h0;
            bus.i_ack   <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.i_rdata <= 32'h0;
            bus.d_rdata <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus.err     <= 1'b0;
            busy_cnt    <= '0;
`endif
        end else begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus.err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_cand | d_cand) begin
                        bus.m_req <= 1'b1;
                        last_d    <= grant_d;
`ifdef MEM_ARB_TIMEOUT_EN
                        busy_cnt  <= '0;
`endif
                        if (grant_d) begin
                            state       <= D_BUSY;
                            bus.m_wr_en <= bus.d_wr_en;
                            bus.m_size  <= bus.d_size;
                            bus.m_sz_ex <= bus.d_sz_ex;
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                        end else begin
                            state       <= I_BUSY;
                            bus.m_wr_en <= 1'b0;
                            bus.m_size  <= 2'b10;
                            bus.m_sz_ex <= 1'b0;
                            bus.m_addr  <= bus.i_addr;
                            bus.m_wdata <= 32'h0;
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (bus.m_rdy) begin
                        bus.m_req <= 1'b0;
                        state     <= IDLE;
                        if (state == D_BUSY) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_rdata <= bus.m_rdata;
                        end else begin
                            bus.i_ack   <= 1'b1;
                            bus.i_rdata <= bus.m_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timed_out) begin
                        bus.m_req <= 1'b0;
                        bus.err   <= 1'b1;
                        state     <= IDLE;
                        if (state == D_BUSY) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_rdata <= 32'h0;
                        end else begin
                            bus.i_ack   <= 1'b1;
                            bus.i_rdata <= 32'h0;
                        end
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb.
// Directed scenarios cover latency, arbitration, waits, reset and timeout.
// A randomized run is then checked against a transaction-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_port_arb;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_port_arb_if bus ();

    mem_port_arb #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_wr_en = 1'b0;
        bus.d_size  = 2'b00;
        bus.d_sz_ex = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.m_rdata = 32'h0;
        bus.m_rdy   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.m_req, bus.m_wr_en, bus.m_size, bus.m_sz_ex} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_mctl: got %b want 00000",
                     {bus.m_req, bus.m_wr_en, bus.m_size, bus.m_sz_ex});
        end
        total++;
        if ({bus.m_addr, bus.m_wdata} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_mbus: got %h want 0", {bus.m_addr, bus.m_wdata});
        end
        total++;
        if ({bus.i_ack, bus.d_ack, bus.err, bus.i_rdata, bus.d_rdata} !== 67'h0) begin
            bad++;
            $display("[TB] FAIL reset_resp: got %h want 0",
                     {bus.i_ack, bus.d_ack, bus.err, bus.i_rdata, bus.d_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.m_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle: m_req got %b want 0", bus.m_req);
        end
    endtask

    task automatic test_single_fetch();
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h100;
        bus.m_rdy   = 1'b1;
        bus.m_rdata = 32'h00000013;
        @(negedge clk);
        total++;
        if ({bus.m_req, bus.m_addr, bus.m_wr_en, bus.m_size, bus.m_sz_ex, bus.m_wdata}
            !== {1'b1, 32'h100, 1'b0, 2'b10, 1'b0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL fetch_cmd: got req=%b addr=%h wr=%b size=%b",
                     bus.m_req, bus.m_addr, bus.m_wr_en, bus.m_size);
        end
        total++;
        if ({bus.i_ack, bus.i_stall} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL fetch_wait: ack,stall got %b want 01", {bus.i_ack, bus.i_stall});
        end
        @(negedge clk);
        total++;
        if ({bus.i_ack, bus.i_stall, bus.m_req, bus.i_rdata} !== {3'b100, 32'h13}) begin
            bad++;
            $display("[TB] FAIL fetch_ack: got ack=%b stall=%b mreq=%b rdata=%h want 1 0 0 13",
                     bus.i_ack, bus.i_stall, bus.m_req, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        bus.m_rdy = 1'b0;
        bus.m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++;
        if ({bus.i_ack, bus.m_req, bus.i_rdata} !== {2'b00, 32'h13}) begin
            bad++;
            $display("[TB] FAIL fetch_hold: got ack=%b mreq=%b rdata=%h want 0 0 13",
                     bus.i_ack, bus.m_req, bus.i_rdata);
        end
    endtask

    task automatic test_timeout();
        int busy;
        int errs;
        bit acked;
        bit ack_err;
        bit ack_mreq;
        logic [31:0] ack_data;
        busy = 0;
        errs = 0;
        acked = 1'b0;
        ack_err = 1'b0;
        ack_mreq = 1'b1;
        ack_data = 32'hx;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h180;
        bus.m_rdy  = 1'b0;
        for (int k = 0; k < 40 && !acked; k++) begin
            @(negedge clk);
            if (bus.i_ack === 1'b1) begin
                acked = 1'b1;
                ack_err = bus.err;
                ack_mreq = bus.m_req;
                ack_data = bus.i_rdata;
            end else begin
                if (bus.m_req === 1'b1) busy++;
                if (bus.err !== 1'b0) errs++;
            end
        end
        bus.i_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        total++;
        if (busy != 16 || !acked) begin
            bad++;
            $display("[TB] FAIL timeout_cycles: busy=%0d acked=%0b want 16 1", busy, acked);
        end
        total++;
        if ({ack_err, ack_mreq, ack_data} !== {2'b10, 32'h0}) begin
            bad++;
            $display("[TB] FAIL timeout_abort: err=%b mreq=%b rdata=%h want 1 0 0",
                     ack_err, ack_mreq, ack_data);
        end
        @(negedge clk);
        total++;
        if ({bus.err, bus.i_ack} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL timeout_pulse: err,ack got %b want 00", {bus.err, bus.i_ack});
        end
`else
        total++;
        if (busy != 40 || acked) begin
            bad++;
            $display("[TB] FAIL wait_forever: busy=%0d acked=%0b want 40 0", busy, acked);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL err_tied: err cycles got %0d want 0", errs);
        end
`endif
    endtask

    task automatic test_conflict();
        idle_inputs();
        rst = 1'b1;
        bus.i_req = 1'b1;  bus.i_addr = 32'h400;
        bus.d_req = 1'b1;  bus.d_addr = 32'h800;  bus.d_size = 2'b10;
        bus.m_rdy = 1'b1;  bus.m_rdata = 32'h11;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h800}) begin
            bad++;
            $display("[TB] FAIL conflict_first: got req=%b addr=%h want 1 800", bus.m_req, bus.m_addr);
        end
        @(negedge clk);
        total++;
        if ({bus.d_ack, bus.i_ack, bus.d_stall, bus.d_rdata} !== {3'b100, 32'h11}) begin
            bad++;
            $display("[TB] FAIL conflict_dack: got dack=%b iack=%b dstall=%b rdata=%h",
                     bus.d_ack, bus.i_ack, bus.d_stall, bus.d_rdata);
        end
        @(negedge clk);
        total++;
        if ({bus.m_req, bus.m_addr, bus.d_ack} !== {1'b1, 32'h400, 1'b0}) begin
            bad++;
            $display("[TB] FAIL conflict_b2b: got req=%b addr=%h dack=%b want 1 400 0",
                     bus.m_req, bus.m_addr, bus.d_ack);
        end
        @(negedge clk);
        total++;
        if ({bus.i_ack, bus.i_rdata} !== {1'b1, 32'h11}) begin
            bad++;
            $display("[TB] FAIL conflict_iack: got ack=%b rdata=%h want 1 11", bus.i_ack, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.m_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL conflict_gap: m_req got %b want 0", bus.m_req);
        end
        bus.i_req = 1'b1;  bus.i_addr = 32'h404;
        bus.d_req = 1'b1;  bus.d_addr = 32'h804;
        bus.m_rdata = 32'h22;
        @(negedge clk);
        total++;
        if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h804}) begin
            bad++;
            $display("[TB] FAIL conflict_second: got req=%b addr=%h want 1 804", bus.m_req, bus.m_addr);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h22}) begin
            bad++;
            $display("[TB] FAIL conflict_dropreq: got ack=%b rdata=%h want 1 22", bus.d_ack, bus.d_rdata);
        end
        bus.m_rdy = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.d_ack, bus.i_ack, bus.m_req} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL conflict_end: got %b want 000", {bus.d_ack, bus.i_ack, bus.m_req});
        end
    endtask

    task automatic test_store_wait();
        bus.d_req   = 1'b1;
        bus.d_wr_en = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_size  = 2'b00;
        bus.d_sz_ex = 1'b0;
        bus.m_rdy   = 1'b0;
        bus.m_rdata = 32'hCAFE0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if ({bus.m_req, bus.m_addr, bus.m_wdata, bus.m_wr_en, bus.m_size, bus.m_sz_ex,
                 bus.d_stall, bus.d_ack} !== {1'b1, 32'h200, 32'hDEADBEEF, 4'b1000, 2'b10}) begin
                bad++;
                $display("[TB] FAIL store_hold%0d: req=%b addr=%h wdata=%h wr=%b size=%b stall=%b ack=%b",
                         k, bus.m_req, bus.m_addr, bus.m_wdata, bus.m_wr_en, bus.m_size,
                         bus.d_stall, bus.d_ack);
            end
        end
        bus.m_rdy = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.d_ack, bus.d_stall, bus.m_req, bus.d_rdata} !== {3'b100, 32'hCAFE0001}) begin
            bad++;
            $display("[TB] FAIL store_ack: got ack=%b stall=%b mreq=%b rdata=%h",
                     bus.d_ack, bus.d_stall, bus.m_req, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        bus.m_rdy = 1'b0;
        @(negedge clk);
        total++;
        if (bus.d_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL store_pulse: d_ack got %b want 0", bus.d_ack);
        end
    endtask

    task automatic test_reset_mid();
        bus.d_req   = 1'b1;
        bus.d_wr_en = 1'b0;
        bus.d_addr  = 32'h300;
        bus.d_size  = 2'b01;
        bus.d_sz_ex = 1'b1;
        bus.m_rdy   = 1'b0;
        bus.m_rdata = 32'h55;
        @(negedge clk);
        total++;
        if (bus.m_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_grant: m_req got %b want 1", bus.m_req);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.m_req, bus.m_addr} !== 33'h0) begin
            bad++;
            $display("[TB] FAIL rstmid_async: got req=%b addr=%h want 0 0", bus.m_req, bus.m_addr);
        end
        @(negedge clk);
        total++;
        if ({bus.d_ack, bus.d_stall} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL rstmid_noack: ack,stall got %b want 01", {bus.d_ack, bus.d_stall});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.m_req, bus.m_addr, bus.m_size, bus.m_sz_ex} !== {1'b1, 32'h300, 3'b011}) begin
            bad++;
            $display("[TB] FAIL rstmid_regrant: got req=%b addr=%h size=%b szex=%b",
                     bus.m_req, bus.m_addr, bus.m_size, bus.m_sz_ex);
        end
        bus.m_rdy = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h55}) begin
            bad++;
            $display("[TB] FAIL rstmid_done: got ack=%b rdata=%h want 1 55", bus.d_ack, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        bus.m_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        // Transaction-level model: one command outstanding at most
        bit          busy;
        bit          owner_d;
        bit          last_d;
        bit          exp_i_ack;
        bit          exp_d_ack;
        bit          ci;
        bit          cd;
        logic [67:0] exp_cmd;
        logic [31:0] exp_i_rdata;
        logic [31:0] exp_d_rdata;
        int          wait_cnt;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busy = 1'b0;
        owner_d = 1'b0;
        last_d = 1'b0;
        exp_i_ack = 1'b0;
        exp_d_ack = 1'b0;
        exp_cmd = '0;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        wait_cnt = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            // Instruction requester
            if (exp_i_ack) begin
                bus.i_req = 1'($urandom_range(0, 1));
                bus.i_addr = $urandom();
            end else if (!bus.i_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.i_req = 1'b1;
                    bus.i_addr = $urandom();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_req = 1'b0;
            end
            // Data requester
            if (exp_d_ack || !bus.d_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.d_req = 1'b1;
                    bus.d_addr = $urandom();
                    bus.d_wdata = $urandom();
                    bus.d_wr_en = 1'($urandom_range(0, 1));
                    bus.d_size = 2'($urandom_range(0, 3));
                    bus.d_sz_ex = 1'($urandom_range(0, 1));
                end else begin
                    bus.d_req = 1'b0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.d_req = 1'b0;
            end
            // Memory: random latency while busy, random noise while idle
            if (busy) begin
                bus.m_rdy = (wait_cnt >= 8) || ($urandom_range(0, 1) == 1);
                wait_cnt++;
            end else begin
                bus.m_rdy = ($urandom_range(0, 2) == 0);
            end
            bus.m_rdata = $urandom();
            #1;
            total++;
            if ({bus.i_stall, bus.d_stall} !== {bus.i_req & ~exp_i_ack, bus.d_req & ~exp_d_ack}) begin
                bad++;
                $display("[TB] FAIL rnd_stall@%0d: got %b want %b", cyc, {bus.i_stall, bus.d_stall},
                         {bus.i_req & ~exp_i_ack, bus.d_req & ~exp_d_ack});
            end
            // Model the coming edge
            ci = bus.i_req & ~exp_i_ack;
            cd = bus.d_req & ~exp_d_ack;
            exp_i_ack = 1'b0;
            exp_d_ack = 1'b0;
            if (!busy) begin
                if (ci || cd) begin
                    owner_d = cd && (!ci || !last_d);
                    last_d = owner_d;
                    busy = 1'b1;
                    wait_cnt = 0;
                    if (owner_d)
                        exp_cmd = {bus.d_addr, bus.d_wr_en, bus.d_size, bus.d_sz_ex, bus.d_wdata};
                    else
                        exp_cmd = {bus.i_addr, 1'b0, 2'b10, 1'b0, 32'h0};
                end
            end else if (bus.m_rdy) begin
                busy = 1'b0;
                if (owner_d) begin
                    exp_d_ack = 1'b1;
                    exp_d_rdata = bus.m_rdata;
                end else begin
                    exp_i_ack = 1'b1;
                    exp_i_rdata = bus.m_rdata;
                end
            end
            @(negedge clk);
            total++;
            if ({bus.m_req, bus.i_ack, bus.d_ack, bus.err} !== {busy, exp_i_ack, exp_d_ack, 1'b0}) begin
                bad++;
                $display("[TB] FAIL rnd_ctl@%0d: req,iack,dack,err got %b want %b", cyc,
                         {bus.m_req, bus.i_ack, bus.d_ack, bus.err},
                         {busy, exp_i_ack, exp_d_ack, 1'b0});
            end
            total++;
            if ({bus.i_rdata, bus.d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
                bad++;
                $display("[TB] FAIL rnd_rdata@%0d: got %h %h want %h %h", cyc,
                         bus.i_rdata, bus.d_rdata, exp_i_rdata, exp_d_rdata);
            end
            if (busy) begin
                total++;
                if ({bus.m_addr, bus.m_wr_en, bus.m_size, bus.m_sz_ex, bus.m_wdata} !== exp_cmd) begin
                    bad++;
                    $display("[TB] FAIL rnd_cmd@%0d: got %h want %h", cyc,
                             {bus.m_addr, bus.m_wr_en, bus.m_size, bus.m_sz_ex, bus.m_wdata}, exp_cmd);
                end
            end
        end
        idle_inputs();
    endtask

    // Scenario sequence and summary
    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        test_reset();
        test_single_fetch();
        test_timeout();
        test_conflict();
        test_store_wait();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
